sp_fifo_ctrl: RTL and testbench
===============================

SP_FIFO_CTRL -- requirements
Module: sp_fifo_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning SRAM word count; fixed at 256, with an 8-bit address.
REQ-002 SHALL have parameter DW, default 128, meaning data width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wr_valid, input, 1, meaning the producer offers wr_data.
REQ-006 SHALL have port wr_ready, output, 1, meaning a write is accepted this cycle when wr_valid is also high.
REQ-007 SHALL have port wr_data, input, DW, the write payload.
REQ-008 SHALL have port rd_valid, output, 1, meaning rd_data is valid.
REQ-009 SHALL have port rd_ready, input, 1, meaning the consumer takes rd_data.
REQ-010 SHALL have port rd_data, output, DW, the head-of-FIFO word.
REQ-011 SHALL have port count, output, 9, total stored words (RAM + in-flight + output buffer), range 0..258.
REQ-012 SHALL have port ram_ceb, output, 1, SRAM chip enable, active-low.
REQ-013 SHALL have port ram_web, output, 1, SRAM write enable, active-low.
REQ-014 SHALL have port ram_a, output, 8, SRAM address.
REQ-015 SHALL have port ram_d, output, DW, SRAM write data.
REQ-016 SHALL have port ram_q, input, DW, SRAM read data, valid exactly 1 cycle after a read access.

Function
REQ-017 SHALL keep 8-bit wptr and rptr that wrap 255->0, plus a 9-bit ram_cnt (0..256); full = ram_cnt==256, empty = ram_cnt==0.
REQ-018 SHALL keep a 2-entry output buffer (ob) with a 2-bit ob_cnt, plus a 1-bit inflight flag for a read issued last cycle.
REQ-019 SHALL compute rd_req = !empty && (ob_cnt + inflight < 2).
REQ-020 SHALL drive wr_ready = !full && (!rd_req || prio==WR); wr_ready SHALL NOT depend on wr_valid.
REQ-021 SHALL grant a write (wr_go) when wr_valid && wr_ready, and grant a read (rd_go) when rd_req && !wr_go; at most one SRAM access per cycle.
REQ-022 SHALL toggle prio only on cycles where rd_req and wr_valid are both high and !full; prio flips to the side not granted.
REQ-023 SHALL drive ram_ceb=0 iff wr_go||rd_go; ram_web=0 iff wr_go; ram_a=wptr on write, rptr on read, else hold last; ram_d=wr_data.
REQ-024 SHALL, on wr_go, increment wptr and ram_cnt; on rd_go, increment rptr and decrement ram_cnt, and set inflight for the next cycle.
REQ-025 SHALL push ram_q into ob at the tail in the cycle when inflight=1; ob SHALL never overflow, as guaranteed by REQ-019.
REQ-026 SHALL drive rd_valid = ob_cnt!=0 and rd_data = ob head; a pop on rd_valid&&rd_ready SHALL be simultaneous-safe with a push (ob_cnt unchanged).
REQ-027 SHALL give a latency from an accepted write into an empty FIFO to rd_valid of 3 cycles (write, read, capture).
REQ-028 SHALL update count as ram_cnt + inflight + ob_cnt, registered; count SHALL be consistent on every cycle.
REQ-029 SHALL, when full with rd_req=0, hold wr_ready=0; an accepted write SHALL never overwrite unread data.

Reset
REQ-030 SHALL, on rst=1 (asynchronous, including mid-transfer), clear wptr, rptr, ram_cnt, ob_cnt, inflight and count to 0, set prio=RD, and force ram_ceb=1, ram_web=1, ram_a=0, wr_ready=0 and rd_valid=0.
REQ-031 SHALL discard any in-flight ram_q after reset; wr_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-032 SHALL, with SP_FIFO_WATERMARK_EN defined, add output max_count[8:0] (the peak of count since reset) and input wm_clr (active-high sync clear; a clear in the same cycle loads the current count).
REQ-033 SHALL, with SP_FIFO_WATERMARK_EN undefined, omit max_count and wm_clr entirely and add no registers.

Verification
REQ-034 SHALL cover: after reset, one write 0xA5.. with rd_ready=1 -> ram_ceb low twice (write, read), rd_valid high 3 cycles after acceptance, rd_data=0xA5.., count returns to 0.
REQ-035 SHALL cover: 258 writes with rd_ready=0 -> wr_ready drops once count=258, ram_cnt=256, and the 259th word is not accepted.
REQ-036 SHALL cover: continuous wr_valid and rd_ready=1 -> reads and writes alternate on the SRAM, with no starvation of either side over 100 cycles.
REQ-037 SHALL cover: 600 words streamed through with random valid/ready -> output order equals input order, and pointer wrap at 255->0 is exercised twice.
REQ-038 SHALL cover: rst asserted while inflight=1 and ob_cnt=1 -> all outputs are at reset values immediately, and the stale ram_q is not presented.
REQ-039 SHALL cover, with SP_FIFO_WATERMARK_EN: fill to 40, drain to 0 -> max_count=40; pulse wm_clr -> max_count=0.

Source files
------------

// File: rtl/sp_fifo_ctrl.sv
// sp_fifo_ctrl: FIFO controller for a single-port synchronous SRAM (256 words).
// One SRAM access per cycle is shared between writes and reads. Reads prefetch
// into a 2-entry output buffer so the consumer sees a registered head word.
// Reads and writes alternate when both sides are competing.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   wr_valid/wr_ready    producer handshake, wr_data payload
//   rd_valid/rd_ready    consumer handshake, rd_data head-of-FIFO word
//   count                stored words (RAM + in-flight read + output buffer)
//   ram_ceb/ram_web      SRAM chip/write enables, active-low
//   ram_a/ram_d/ram_q    SRAM address, write data, read data (1-cycle latency)
//
// Optional feature (macro SP_FIFO_WATERMARK_EN):
//   max_count            peak of count since reset
//   wm_clr               synchronous clear; loads the current count
module sp_fifo_ctrl #(
    parameter int DEPTH = 256,
    parameter int DW    = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [8:0]    count,
    output logic          ram_ceb,
    output logic          ram_web,
    output logic [7:0]    ram_a,
    output logic [DW-1:0] ram_d,
    input  logic [DW-1:0] ram_q
`ifdef SP_FIFO_WATERMARK_EN
    ,
    output logic [8:0]    max_count,
    input  logic          wm_clr
`endif
);

    localparam logic [8:0] FULL_CNT = 9'(DEPTH);

    typedef enum logic {
        PRIO_RD,
        PRIO_WR
    } prio_t;

    logic [7:0]    wptr;
    logic [7:0]    rptr;
    logic [8:0]    ram_cnt;
    logic [1:0]    ob_cnt;
    logic          inflight;
    prio_t         prio;
    logic [7:0]    ram_a_q;
    logic [DW-1:0] ob [2];

    logic          full;
    logic          empty;
    logic          rd_req;
    logic          wr_go;
    logic          rd_go;
    logic          pop;
    logic          tail;
    logic [8:0]    ram_cnt_n;
    logic [1:0]    ob_cnt_n;
    logic [8:0]    count_n;

    always_comb begin
        full      = (ram_cnt == FULL_CNT);
        empty     = (ram_cnt == '0);
        // Only prefetch when the buffer has room for the word once it lands.
        rd_req    = !empty && (({1'b0, ob_cnt} + {2'b00, inflight}) < 3'd2);
        wr_ready  = !rst && !full && (!rd_req || prio == PRIO_WR);
        wr_go     = wr_valid && wr_ready;
        rd_go     = !rst && rd_req && !wr_go;

        ram_ceb   = !(wr_go || rd_go);
        ram_web   = !wr_go;
        ram_a     = wr_go ? wptr : (rd_go ? rptr : ram_a_q);
        ram_d     = wr_data;

        rd_valid  = (ob_cnt != 2'd0);
        rd_data   = ob[0];
        pop       = rd_valid && rd_ready;
        // Slot the returning word lands in, after any same-cycle pop shift.
        tail      = (ob_cnt == 2'd2) || (ob_cnt == 2'd1 && !pop);

        ram_cnt_n = ram_cnt + 9'(wr_go) - 9'(rd_go);
        ob_cnt_n  = ob_cnt + {1'b0, inflight} - {1'b0, pop};
        // count is registered from next-state values so it matches the
        // stored contents on every cycle.
        count_n   = ram_cnt_n + {8'b0, rd_go} + {7'b0, ob_cnt_n};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            ob_cnt   <= '0;
            inflight <= 1'b0;
            count    <= '0;
            prio     <= PRIO_RD;
            ram_a_q  <= '0;
            ob[0]    <= '0;
            ob[1]    <= '0;
        end else begin
            if (wr_go) wptr <= wptr + 8'd1;
            if (rd_go) rptr <= rptr + 8'd1;
            ram_cnt  <= ram_cnt_n;
            ob_cnt   <= ob_cnt_n;
            inflight <= rd_go;
            count    <= count_n;
            ram_a_q  <= ram_a;
            // Contended cycle: hand priority to whichever side lost.
            if (rd_req && wr_valid && !full)
                prio <= (prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
            if (pop) ob[0] <= ob[1];
            if (inflight) ob[tail] <= ram_q;
        end
    end

`ifdef SP_FIFO_WATERMARK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_count <= '0;
        end else if (wm_clr) begin
            max_count <= count;
        end else if (count > max_count) begin
            max_count <= count;
        end
    end
`endif

endmodule

// File: tb/tb_sp_fifo_ctrl.sv
// Self-checking bench for sp_fifo_ctrl with a behavioural SRAM and a queue
// reference model of the FIFO contents.
module tb_sp_fifo_ctrl;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [8:0]    count;
    logic          ram_ceb;
    logic          ram_web;
    logic [7:0]    ram_a;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;
`ifdef SP_FIFO_WATERMARK_EN
    logic [8:0]    max_count;
    logic          wm_clr;
`endif

    always #5 clk = ~clk;

    sp_fifo_ctrl #(.DEPTH(256), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .ram_ceb  (ram_ceb),
        .ram_web  (ram_web),
        .ram_a    (ram_a),
        .ram_d    (ram_d),
        .ram_q    (ram_q)
`ifdef SP_FIFO_WATERMARK_EN
        ,
        .max_count(max_count),
        .wm_clr   (wm_clr)
`endif
    );

    // Single-port synchronous SRAM, read data one cycle after the access.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (!ram_ceb) begin
            if (!ram_web) mem[ram_a] <= ram_d;
            else          ram_q <= mem[ram_a];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] model_q [$];
    int ceb_low_cnt, rd_acc_cnt, wr_acc_cnt, pop_cnt, wr_cnt;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clear_stats();
        ceb_low_cnt = 0; rd_acc_cnt = 0; wr_acc_cnt = 0; pop_cnt = 0; wr_cnt = 0;
    endtask

    // One clock cycle: drive at negedge, observe, then account for the
    // handshakes that complete at the following rising edge.
    task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rr);
        logic [DW-1:0] exp;
        @(negedge clk);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        #1;
        chk("count", count, model_q.size());
        chk("wr_access", !ram_web, wr_valid && wr_ready);
        if (model_q.size() >= 258) chk("full_wr_ready", wr_ready, 1'b0);
        if (!ram_web) chk("ram_d", ram_d, wd);
        if (!ram_ceb) begin
            ceb_low_cnt++;
            if (ram_web) rd_acc_cnt++;
            else         wr_acc_cnt++;
        end
        if (rd_valid && rd_ready) begin
            if (model_q.size() == 0) begin
                chk("spurious_rd_valid", 1'b1, 1'b0);
            end else begin
                exp = model_q.pop_front();
                chk("rd_data", rd_data, exp);
            end
            pop_cnt++;
        end
        if (wr_valid && wr_ready) begin
            model_q.push_back(wd);
            wr_cnt++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_ready"}, wr_ready, 1'b0);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_count"},    count,    9'd0);
        chk({tag, "_ram_ceb"},  ram_ceb,  1'b1);
        chk({tag, "_ram_web"},  ram_web,  1'b1);
        chk({tag, "_ram_a"},    ram_a,    8'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        #1;
        chk("post_rst_wr_ready", wr_ready, 1'b1);
        chk("post_rst_rd_valid", rd_valid, 1'b0);
        chk("post_rst_count",    count,    9'd0);
    endtask

    task automatic apply_reset();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        wr_data  = '0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        release_reset();
        clear_stats();
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while ((model_q.size() != 0 || rd_valid) && guard < 1000) begin
            cycle(1'b0, '0, 1'b1);
            guard++;
        end
        chk({tag, "_drain_done"}, guard < 1000, 1'b1);
        cycle(1'b0, '0, 1'b0);
        chk({tag, "_drain_count"}, count, 9'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a5;
        logic [DW-1:0] cur;
        int            guard;
        int            prev_wr;
        logic          wv;
        logic          rr;

        a5       = {16{8'hA5}};
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        wr_data  = '0;
`ifdef SP_FIFO_WATERMARK_EN
        wm_clr   = 1'b0;
`endif
        rst      = 1'b1;
        #1;
        check_reset_outputs("init");

        // Single word: write, read, capture, then visible.
        apply_reset();
        cycle(1'b1, a5, 1'b1);
        chk("t1_accepted", wr_cnt, 1);
        cycle(1'b0, '0, 1'b1);
        chk("t1_rv_c1", rd_valid, 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("t1_rv_c2", rd_valid, 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("t1_rv_c3", rd_valid, 1'b1);
        chk("t1_rd_data", rd_data, a5);
        cycle(1'b0, '0, 1'b1);
        chk("t1_count_end", count, 9'd0);
        chk("t1_ceb_lows", ceb_low_cnt, 2);
        chk("t1_pops", pop_cnt, 1);

        // Fill with consumer stalled: capacity is RAM plus output buffer.
        apply_reset();
        repeat (400) cycle(1'b1, rand_word(), 1'b0);
        chk("t2_accepted", wr_cnt, 258);
        chk("t2_count", count, 9'd258);
        chk("t2_wr_ready", wr_ready, 1'b0);
        drain("t2");
        chk("t2_pops", pop_cnt, 258);

        // Both sides always active: SRAM must serve each side about half the time.
        apply_reset();
        repeat (100) cycle(1'b1, rand_word(), 1'b1);
        chk("t3_writes_served", wr_acc_cnt >= 45, 1'b1);
        chk("t3_reads_served", rd_acc_cnt >= 45, 1'b1);
        chk("t3_pops", pop_cnt >= 40, 1'b1);
        drain("t3");

        // Random valid/ready stream, 600 words (pointers wrap twice).
        apply_reset();
        cur   = rand_word();
        guard = 0;
        while (pop_cnt < 600 && guard < 20000) begin
            wv      = (wr_cnt < 600) && ($urandom_range(0, 3) != 0);
            rr      = ($urandom_range(0, 2) != 0);
            prev_wr = wr_cnt;
            cycle(wv, cur, rr);
            if (wr_cnt != prev_wr) cur = rand_word();
            guard++;
        end
        chk("t4_written", wr_cnt, 600);
        chk("t4_popped", pop_cnt, 600);
        cycle(1'b0, '0, 1'b0);
        chk("t4_count_end", count, 9'd0);

        // Reset while a read is in flight and the buffer holds one word.
        apply_reset();
        guard = 0;
        while (rd_acc_cnt < 2 && guard < 20) begin
            cycle(1'b1, rand_word(), 1'b0);
            guard++;
        end
        chk("t5_reached_state", rd_acc_cnt, 2);
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_pre_rv", rd_valid, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        @(posedge clk);
        #1;
        check_reset_outputs("t5_held");
        release_reset();
        clear_stats();
        repeat (4) begin
            cycle(1'b0, '0, 1'b1);
            chk("t5_no_stale", rd_valid, 1'b0);
        end

`ifdef SP_FIFO_WATERMARK_EN
        // Watermark: peak tracking and synchronous clear.
        apply_reset();
        guard = 0;
        while (wr_cnt < 40 && guard < 200) begin
            cycle(1'b1, rand_word(), 1'b0);
            guard++;
        end
        cycle(1'b0, '0, 1'b0);
        chk("t6_count40", count, 9'd40);
        drain("t6");
        cycle(1'b0, '0, 1'b0);
        chk("t6_max_count", max_count, 9'd40);
        @(negedge clk);
        wm_clr = 1'b1;
        @(negedge clk);
        wm_clr = 1'b0;
        #1;
        chk("t6_wm_clr", max_count, 9'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
